// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I datapath: IDLE->FETCH->DECODE->EXEC->[MEM]->WB.
// Drives memory handshakes and datapath strobes; owns halt/error status and the retired counter.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_reg_wr,
    input  logic             dec_mem_rd,
    input  logic             dec_mem_wr,
    input  logic             dec_branch,
    input  logic             dec_jal,
    input  logic             dec_jalr,
    input  logic             dec_halt,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit HAS_TIMEOUT = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instret_q;
    logic               halted_q;
    logic               err_q;
    logic               timeout_hit;

    // Next-state and per-cycle strobes decoded from the registered state.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 2'b00;
        timeout_hit = HAS_TIMEOUT && (wait_cnt == WAIT_LAST);

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                if (dec_halt)
                    state_d = S_HALT;
                else if (dec_mem_rd && dec_mem_wr)
                    state_d = S_ERR;
                else
                    state_d = S_EXEC;
            end
            S_EXEC: state_d = (dec_mem_rd || dec_mem_wr) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_wr;
                if (dmem_ready)
                    state_d = S_WB;
                else if (timeout_hit)
                    state_d = S_ERR;
            end
            S_WB: begin
                rf_we = dec_reg_wr;
                pc_en = 1'b1;
                if (dec_jalr)
                    pc_sel = 2'b10;
                else if (dec_jal || (dec_branch && br_taken))
                    pc_sel = 2'b01;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // State, wait counter (cleared on each state change), retire counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_cnt  <= '0;
            instret_q <= '0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (state_q == S_FETCH || state_q == S_MEM)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state_q == S_WB || (state_q == S_DECODE && state_d == S_HALT))
                instret_q <= instret_q + CNT_W'(1);
            if (state_d == S_HALT)
                halted_q <= 1'b1;
            if (state_d == S_ERR)
                err_q <= 1'b1;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;
    assign halted  = halted_q;
    assign err     = err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: hand-computed state/strobe sequences per instruction class.
module tb_multicycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic        dec_reg_wr, dec_mem_rd, dec_mem_wr, dec_branch, dec_jal, dec_jalr, dec_halt;
    logic        br_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en;
    logic [1:0]  pc_sel;
    logic        halted, err;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [7:0]  strb_vec;

    int n_tests = 0;
    int n_fail  = 0;

    // Decode flag order: {reg_wr, mem_rd, mem_wr, branch, jal, jalr, halt}
    localparam logic [6:0] D_NONE = 7'b0000000;
    localparam logic [6:0] D_ADD  = 7'b1000000;
    localparam logic [6:0] D_LW   = 7'b1100000;
    localparam logic [6:0] D_SW   = 7'b0010000;
    localparam logic [6:0] D_BEQ  = 7'b0001000;
    localparam logic [6:0] D_JAL  = 7'b1000100;
    localparam logic [6:0] D_JALR = 7'b1000010;
    localparam logic [6:0] D_ALL  = 7'b1001110;
    localparam logic [6:0] D_ILL  = 7'b0110000;
    localparam logic [6:0] D_EBRK = 7'b0000001;

    // Strobe order: {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel[1:0]}
    localparam logic [7:0] X_NONE  = 8'b0000_0000;
    localparam logic [7:0] X_FWAIT = 8'b1000_0000;
    localparam logic [7:0] X_FETCH = 8'b1100_0000;
    localparam logic [7:0] X_LD    = 8'b0010_0000;
    localparam logic [7:0] X_ST    = 8'b0011_0000;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3;
    localparam logic [2:0] MEM = 3'd4, WB = 3'd5, HALT = 3'd6, ERR = 3'd7;

    multicycle_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_reg_wr(dec_reg_wr), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
        .dec_branch(dec_branch), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_halt(dec_halt),
        .br_taken(br_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_en(pc_en), .pc_sel(pc_sel), .halted(halted), .err(err),
        .state(state), .instret(instret)
    );

    assign strb_vec = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, pc_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic [6:0] d);
        {dec_reg_wr, dec_mem_rd, dec_mem_wr, dec_branch, dec_jal, dec_jalr, dec_halt} = d;
    endtask

    // Check state and strobes for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] strb);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strb"}, 32'(strb_vec), 32'(strb));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(IDLE));
        chk({tag, ".strb"}, 32'(strb_vec), 32'(X_NONE));
        chk({tag, ".instret"}, instret, 32'd0);
        chk({tag, ".halted"}, 32'(halted), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
        rst_n = 1'b1;
        cyc({tag, ".idle"}, IDLE, X_NONE);
    endtask

    task automatic nonmem(input string tag, input logic [6:0] d, input logic br, input logic [7:0] wb);
        set_dec(d);
        br_taken   = br;
        imem_ready = 1'b1;
        cyc({tag, ".fetch"}, FETCH, X_FETCH);
        imem_ready = 1'b0;
        cyc({tag, ".decode"}, DECODE, X_NONE);
        cyc({tag, ".exec"}, EXEC, X_NONE);
        cyc({tag, ".wb"}, WB, wb);
    endtask

    initial begin
        rst_n = 1'b0;
        set_dec(D_NONE);
        br_taken   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        do_reset("por");

        // ADD with immediate fetch ready
        nonmem("add", D_ADD, 1'b0, 8'b0000_1100);
        chk("add.instret", instret, 32'd1);

        // LW with memory ready on the final allowed wait cycle
        set_dec(D_LW);
        imem_ready = 1'b1;
        cyc("lw.fetch", FETCH, X_FETCH);
        imem_ready = 1'b0;
        cyc("lw.decode", DECODE, X_NONE);
        cyc("lw.exec", EXEC, X_NONE);
        repeat (3) cyc("lw.memwait", MEM, X_LD);
        dmem_ready = 1'b1;
        cyc("lw.memdone", MEM, X_LD);
        dmem_ready = 1'b0;
        cyc("lw.wb", WB, 8'b0000_1100);
        chk("lw.instret", instret, 32'd2);

        // SW, ready immediately
        set_dec(D_SW);
        imem_ready = 1'b1;
        cyc("sw.fetch", FETCH, X_FETCH);
        imem_ready = 1'b0;
        cyc("sw.decode", DECODE, X_NONE);
        cyc("sw.exec", EXEC, X_NONE);
        dmem_ready = 1'b1;
        cyc("sw.mem", MEM, X_ST);
        dmem_ready = 1'b0;
        cyc("sw.wb", WB, 8'b0000_0100);
        chk("sw.instret", instret, 32'd3);

        nonmem("beq_t", D_BEQ, 1'b1, 8'b0000_0101);
        nonmem("beq_nt", D_BEQ, 1'b0, 8'b0000_0100);
        nonmem("jalr", D_JALR, 1'b0, 8'b0000_1110);
        nonmem("jal", D_JAL, 1'b0, 8'b0000_1101);
        nonmem("prio", D_ALL, 1'b1, 8'b0000_1110);
        chk("ctl.instret", instret, 32'd8);

        // Illegal decode (load and store together) goes to ERR without retiring
        set_dec(D_ILL);
        imem_ready = 1'b1;
        cyc("ill.fetch", FETCH, X_FETCH);
        imem_ready = 1'b0;
        cyc("ill.decode", DECODE, X_NONE);
        chk("ill.err", 32'(err), 32'd1);
        chk("ill.instret", instret, 32'd8);
        imem_ready = 1'b1;
        cyc("ill.err0", ERR, X_NONE);
        cyc("ill.err1", ERR, X_NONE);
        imem_ready = 1'b0;
        do_reset("rst1");

        // EBREAK halts, retires once, and stays quiet
        set_dec(D_EBRK);
        imem_ready = 1'b1;
        cyc("halt.fetch", FETCH, X_FETCH);
        cyc("halt.decode", DECODE, X_NONE);
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.instret", instret, 32'd1);
        repeat (3) cyc("halt.hold", HALT, X_NONE);
        chk("halt.instret_hold", instret, 32'd1);
        chk("halt.err", 32'(err), 32'd0);
        imem_ready = 1'b0;
        do_reset("rst2");

        // Fetch timeout: request held exactly TIMEOUT cycles
        set_dec(D_NONE);
        repeat (4) cyc("to.fetch", FETCH, X_FWAIT);
        chk("to.err", 32'(err), 32'd1);
        cyc("to.errstate", ERR, X_NONE);
        chk("to.instret", instret, 32'd0);
        do_reset("rst3");

        // Reset during a memory wait abandons the request
        nonmem("pre", D_ADD, 1'b0, 8'b0000_1100);
        chk("pre.instret", instret, 32'd1);
        set_dec(D_LW);
        imem_ready = 1'b1;
        cyc("mr.fetch", FETCH, X_FETCH);
        imem_ready = 1'b0;
        cyc("mr.decode", DECODE, X_NONE);
        cyc("mr.exec", EXEC, X_NONE);
        cyc("mr.mem0", MEM, X_LD);
        rst_n = 1'b0;
        cyc("mr.mem1", MEM, X_LD);
        chk("mr.instret", instret, 32'd0);
        rst_n = 1'b1;
        cyc("mr.idle", IDLE, X_NONE);
        cyc("mr.refetch", FETCH, X_FWAIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
